// File: rtl/oric_tap_pkg.sv
// Shared types and byte constants for the Oric .TAP fast loader.
package oric_tap_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, HDR, NAME, DATA, DONE, ERR} state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'h16;
  localparam logic [7:0] MARK_BYTE  = 8'h24;
  localparam int         HDR_LEN    = 9;
  localparam logic [7:0] TYPE_BASIC = 8'h00;
  localparam logic [7:0] TYPE_MC    = 8'h80;

endpackage

// File: rtl/oric_tap_loader_fetcher.sv
// Sequential byte reader for the tape cache: one read per byte, RD_LAT delay line,
// and an end-of-tape pulse instead of a read when the next byte lies past tape_end.
module tap_byte_fetcher #(
  parameter int AW     = 25,
  parameter int RD_LAT = 1
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic          fetch_start,
  input  logic          fetch_next,
  input  logic [AW-1:0] tape_end,
  output logic [AW-1:0] cache_addr,
  output logic          cache_rd,
  input  logic [7:0]    cache_data,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          eof
);

  logic [RD_LAT-1:0] pipe_r;
  logic [AW-1:0]     addr_r;
  logic              rd_r;
  logic              eof_r;
  logic [AW:0]       addr_inc_s;

  assign addr_inc_s = {1'b0, addr_r} + {{AW{1'b0}}, 1'b1};
  assign byte_valid = pipe_r[RD_LAT-1];
  assign byte_data  = cache_data;
  assign cache_addr = addr_r;
  assign cache_rd   = rd_r;
  assign eof        = eof_r;

  // Read issue, latency tracking and bound check; the next read is decided in the consume cycle.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      pipe_r <= '0;
      addr_r <= '0;
      rd_r   <= 1'b0;
      eof_r  <= 1'b0;
    end else begin
      rd_r   <= 1'b0;
      eof_r  <= 1'b0;
      pipe_r <= (pipe_r << 1'b1) | RD_LAT'(rd_r);
      if (fetch_start) begin
        addr_r <= '0;
        rd_r   <= 1'b1;
      end else if (byte_valid) begin
        addr_r <= addr_inc_s[AW-1:0];
        if (fetch_next) begin
          if (addr_inc_s > {1'b0, tape_end}) begin
            eof_r <= 1'b1;
          end else begin
            rd_r <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/oric_tap_loader.sv
// Oric .TAP parser: finds sync + header, skips the filename and streams the first
// program's data straight into main RAM, then reports load point and autorun.
module oric_tap_loader
  import oric_tap_pkg::*;
#(
  parameter int AW       = 25,
  parameter int MIN_SYNC = 3,
  parameter int NAME_MAX = 16,
  parameter int RD_LAT   = 1
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] tape_end,
  output logic [AW-1:0] cache_addr,
  output logic          cache_rd,
  input  logic [7:0]    cache_data,
  output logic [15:0]   ram_addr,
  output logic [7:0]    ram_dout,
  output logic          ram_wr,
  output logic [15:0]   loadpoint,
  output logic          autorun,
  output logic          busy,
  output logic          complete,
  output logic          error
);

  localparam int SCW = $clog2(MIN_SYNC + 1);
  localparam int NCW = $clog2(NAME_MAX + 1);

  state_t          state_r;
  logic [SCW-1:0]  sync_cnt_r;
  logic [3:0]      hdr_idx_r;
  logic [NCW-1:0]  name_cnt_r;
  logic [15:0]     end_r;
  logic [15:0]     start_r;
  logic [15:0]     ptr_r;
  logic [16:0]     rem_r;
  logic            autorun_hdr_r;

  logic            fetch_start_s;
  logic            fetch_next_s;
  logic            byte_valid_s;
  logic [7:0]      byte_s;
  logic            eof_s;

  assign fetch_start_s = (state_r == IDLE) && start;

  tap_byte_fetcher #(.AW(AW), .RD_LAT(RD_LAT)) u_fetch (
    .clk_48     (clk_48),
    .reset      (reset),
    .fetch_start(fetch_start_s),
    .fetch_next (fetch_next_s),
    .tape_end   (tape_end),
    .cache_addr (cache_addr),
    .cache_rd   (cache_rd),
    .cache_data (cache_data),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_s),
    .eof        (eof_s)
  );

  // Whether the parser still needs a byte after the one being consumed now.
  always_comb begin
    fetch_next_s = 1'b0;
    case (state_r)
      SYNC: fetch_next_s = 1'b1;
      HDR: begin
        if ((hdr_idx_r == 4'(HDR_LEN - 1)) && (end_r < start_r)) begin
          fetch_next_s = 1'b0;
        end else begin
          fetch_next_s = 1'b1;
        end
      end
      NAME: begin
        if ((byte_s != 8'h00) && (name_cnt_r == NCW'(NAME_MAX))) begin
          fetch_next_s = 1'b0;
        end else begin
          fetch_next_s = 1'b1;
        end
      end
      DATA: fetch_next_s = (rem_r > 17'd1);
      default: fetch_next_s = 1'b0;
    endcase
  end

  // Parser FSM and all registered outputs.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_r       <= IDLE;
      sync_cnt_r    <= '0;
      hdr_idx_r     <= 4'd0;
      name_cnt_r    <= '0;
      end_r         <= 16'h0000;
      start_r       <= 16'h0000;
      ptr_r         <= 16'h0000;
      rem_r         <= 17'd0;
      autorun_hdr_r <= 1'b0;
      ram_addr      <= 16'h0000;
      ram_dout      <= 8'h00;
      ram_wr        <= 1'b0;
      loadpoint     <= 16'h0000;
      autorun       <= 1'b0;
      busy          <= 1'b0;
      complete      <= 1'b0;
      error         <= 1'b0;
    end else begin
      ram_wr <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= SYNC;
            sync_cnt_r <= '0;
            complete   <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SYNC: begin
          if (eof_s) begin
            state_r <= ERR;
          end else if (byte_valid_s) begin
            if (byte_s == SYNC_BYTE) begin
              if (sync_cnt_r < SCW'(MIN_SYNC)) sync_cnt_r <= sync_cnt_r + SCW'(1);
            end else if ((byte_s == MARK_BYTE) && (sync_cnt_r >= SCW'(MIN_SYNC))) begin
              state_r    <= HDR;
              hdr_idx_r  <= 4'd0;
              sync_cnt_r <= '0;
            end else begin
              sync_cnt_r <= '0;
            end
          end
        end
        HDR: begin
          if (eof_s) begin
            state_r <= ERR;
          end else if (byte_valid_s) begin
            hdr_idx_r <= hdr_idx_r + 4'd1;
            case (hdr_idx_r)
              4'd3: autorun_hdr_r  <= (byte_s != 8'h00);
              4'd4: end_r[15:8]    <= byte_s;
              4'd5: end_r[7:0]     <= byte_s;
              4'd6: start_r[15:8]  <= byte_s;
              4'd7: start_r[7:0]   <= byte_s;
              4'd8: begin
                if (end_r < start_r) begin
                  state_r <= ERR;
                end else begin
                  state_r    <= NAME;
                  name_cnt_r <= '0;
                  ptr_r      <= start_r;
                  // 17-bit so a full 0000..FFFF image yields 65536
                  rem_r      <= {1'b0, end_r} - {1'b0, start_r} + 17'd1;
                end
              end
              default: ;
            endcase
          end
        end
        NAME: begin
          if (eof_s) begin
            state_r <= ERR;
          end else if (byte_valid_s) begin
            if (byte_s == 8'h00) begin
              state_r <= DATA;
            end else if (name_cnt_r == NCW'(NAME_MAX)) begin
              state_r <= ERR;
            end else begin
              name_cnt_r <= name_cnt_r + NCW'(1);
            end
          end
        end
        DATA: begin
          if (rem_r == 17'd0) begin
            state_r <= DONE;
          end else if (eof_s) begin
            state_r <= ERR;
          end else if (byte_valid_s) begin
            ram_addr <= ptr_r;
            ram_dout <= byte_s;
            ram_wr   <= 1'b1;
            ptr_r    <= ptr_r + 16'd1;
            rem_r    <= rem_r - 17'd1;
          end
        end
        DONE: begin
          complete  <= 1'b1;
          busy      <= 1'b0;
          loadpoint <= start_r;
          autorun   <= autorun_hdr_r;
          state_r   <= IDLE;
        end
        ERR: begin
          error    <= 1'b1;
          busy     <= 1'b0;
          complete <= 1'b0;
          state_r  <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oric_tap_loader.sv
// Directed bench for oric_tap_loader: cache and RAM models, one task per scenario.
module tb_oric_tap_loader;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        start;
  logic [24:0] tape_end;
  logic [24:0] cache_addr;
  logic        cache_rd;
  logic [7:0]  cache_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [15:0] loadpoint;
  logic        autorun;
  logic        busy;
  logic        complete;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:255];
  logic [7:0]  ram [0:65535];
  int          wr_count = 0;
  int          past_end = 0;
  logic [24:0] last_rd = 25'd0;
  logic [7:0]  img [$];

  always #10 clk_48 = ~clk_48;

  oric_tap_loader dut (
    .clk_48    (clk_48),
    .reset     (reset),
    .start     (start),
    .tape_end  (tape_end),
    .cache_addr(cache_addr),
    .cache_rd  (cache_rd),
    .cache_data(cache_data),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .loadpoint (loadpoint),
    .autorun   (autorun),
    .busy      (busy),
    .complete  (complete),
    .error     (error)
  );

  // Cache with one cycle read latency, RAM model and read monitor.
  always @(posedge clk_48) begin
    cache_data <= mem[cache_addr[7:0]];
    if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
      wr_count <= wr_count + 1;
    end
    if (cache_rd) begin
      last_rd <= cache_addr;
      if (cache_addr > tape_end) past_end <= past_end + 1;
    end
  end

  task automatic load_img();
    for (int i = 0; i < 256; i++) mem[i] = (i < img.size()) ? img[i] : 8'hEE;
    tape_end = 25'(img.size() - 1);
  endtask

  task automatic push_hdr(input logic [7:0] ar, input logic [15:0] e, input logic [15:0] s);
    img.push_back(8'h16); img.push_back(8'h16); img.push_back(8'h16); img.push_back(8'h24);
    img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h80); img.push_back(ar);
    img.push_back(e[15:8]); img.push_back(e[7:0]); img.push_back(s[15:8]); img.push_back(s[7:0]);
    img.push_back(8'h00);
  endtask

  task automatic run_load(input string name);
    @(negedge clk_48) start = 1'b1;
    @(negedge clk_48) start = 1'b0;
    for (int i = 0; i < 3000 && !(complete || error); i++) @(negedge clk_48);
    checks++;
    if (!(complete || error)) begin
      errors++;
      $display("FAIL %s_timeout got complete=%b error=%b want a flag set", name, complete, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tape_end = 25'd0;
    repeat (3) @(negedge clk_48);
    reset = 1'b0;
    @(negedge clk_48);
    checks++;
    if ({busy, complete, error, ram_wr, cache_rd, autorun} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {busy, complete, error, ram_wr, cache_rd, autorun});
    end
    checks++;
    if ({cache_addr, ram_addr, ram_dout, loadpoint} !== 65'd0) begin
      errors++;
      $display("FAIL reset_buses got %h want 0", {cache_addr, ram_addr, ram_dout, loadpoint});
    end
  endtask

  task automatic test_basic();
    int base;
    img.delete();
    push_hdr(8'hC7, 16'h5003, 16'h5000);
    img.push_back(8'h41); img.push_back(8'h00);
    img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC); img.push_back(8'hDD);
    load_img();
    base = wr_count;
    run_load("basic");
    checks++;
    if ({complete, error, busy} !== 3'b100) begin
      errors++; $display("FAIL basic_status got %b want 100", {complete, error, busy});
    end
    checks++;
    if (loadpoint !== 16'h5000 || autorun !== 1'b1) begin
      errors++; $display("FAIL basic_lp got %h/%b want 5000/1", loadpoint, autorun);
    end
    checks++;
    if (wr_count - base !== 4) begin
      errors++; $display("FAIL basic_wrs got %0d want 4", wr_count - base);
    end
    checks++;
    if ({ram[16'h5000], ram[16'h5001], ram[16'h5002], ram[16'h5003]} !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL basic_ram got %h want AABBCCDD",
               {ram[16'h5000], ram[16'h5001], ram[16'h5002], ram[16'h5003]});
    end
  endtask

  task automatic test_early_marker();
    int base;
    img.delete();
    img.push_back(8'h16); img.push_back(8'h16); img.push_back(8'h24);
    push_hdr(8'h00, 16'h0401, 16'h0400);
    img.push_back(8'h42); img.push_back(8'h00); img.push_back(8'h55); img.push_back(8'h66);
    load_img();
    base = wr_count;
    run_load("early");
    checks++;
    if ({complete, error, busy} !== 3'b100) begin
      errors++; $display("FAIL early_status got %b want 100", {complete, error, busy});
    end
    checks++;
    if (loadpoint !== 16'h0400 || autorun !== 1'b0) begin
      errors++; $display("FAIL early_lp got %h/%b want 0400/0", loadpoint, autorun);
    end
    checks++;
    if (wr_count - base !== 2 || {ram[16'h0400], ram[16'h0401]} !== 16'h5566) begin
      errors++;
      $display("FAIL early_ram got %0d/%h want 2/5566", wr_count - base, {ram[16'h0400], ram[16'h0401]});
    end
  endtask

  task automatic test_bad_range();
    int base;
    img.delete();
    push_hdr(8'h01, 16'h4FFF, 16'h5000);
    img.push_back(8'h43); img.push_back(8'h00); img.push_back(8'h11); img.push_back(8'h22);
    load_img();
    base = wr_count;
    run_load("range");
    checks++;
    if ({complete, error, busy} !== 3'b010) begin
      errors++; $display("FAIL range_status got %b want 010", {complete, error, busy});
    end
    checks++;
    if (wr_count - base !== 0) begin
      errors++; $display("FAIL range_wrs got %0d want 0", wr_count - base);
    end
  endtask

  task automatic test_truncated();
    int base;
    img.delete();
    push_hdr(8'hC7, 16'h5003, 16'h5000);
    img.push_back(8'h41); img.push_back(8'h00);
    img.push_back(8'h31); img.push_back(8'h32); img.push_back(8'h33); img.push_back(8'h34);
    load_img();
    tape_end = 25'd16;
    base = wr_count;
    run_load("trunc");
    checks++;
    if ({complete, error, busy} !== 3'b010) begin
      errors++; $display("FAIL trunc_status got %b want 010", {complete, error, busy});
    end
    checks++;
    if (wr_count - base !== 2) begin
      errors++; $display("FAIL trunc_wrs got %0d want 2", wr_count - base);
    end
    checks++;
    if ({ram[16'h5000], ram[16'h5001], ram[16'h5002], ram[16'h5003]} !== 32'h3132CCDD) begin
      errors++;
      $display("FAIL trunc_ram got %h want 3132CCDD",
               {ram[16'h5000], ram[16'h5001], ram[16'h5002], ram[16'h5003]});
    end
    checks++;
    if (last_rd !== 25'd16 || past_end !== 0) begin
      errors++; $display("FAIL trunc_bound got %0d/%0d want 16/0", last_rd, past_end);
    end
  endtask

  task automatic test_name_limit();
    int base;
    img.delete();
    push_hdr(8'h00, 16'h5000, 16'h5000);
    for (int i = 0; i < 17; i++) img.push_back(8'h4E);
    img.push_back(8'h00); img.push_back(8'h77);
    load_img();
    base = wr_count;
    run_load("name17");
    checks++;
    if ({complete, error, busy} !== 3'b010 || wr_count - base !== 0) begin
      errors++;
      $display("FAIL name17_status got %b/%0d want 010/0", {complete, error, busy}, wr_count - base);
    end
    checks++;
    if (last_rd !== 25'd29) begin
      errors++; $display("FAIL name17_stop got %0d want 29", last_rd);
    end
    img.delete();
    push_hdr(8'h01, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 16; i++) img.push_back(8'h4D);
    img.push_back(8'h00); img.push_back(8'h9A); img.push_back(8'h9B);
    load_img();
    base = wr_count;
    run_load("ffff");
    checks++;
    if ({complete, error, busy} !== 3'b100 || loadpoint !== 16'hFFFF || autorun !== 1'b1) begin
      errors++;
      $display("FAIL ffff_status got %b/%h/%b want 100/ffff/1", {complete, error, busy}, loadpoint, autorun);
    end
    checks++;
    if (wr_count - base !== 1 || ram[16'hFFFF] !== 8'h9A || last_rd !== 25'd30) begin
      errors++;
      $display("FAIL ffff_write got %0d/%h/%0d want 1/9a/30", wr_count - base, ram[16'hFFFF], last_rd);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int i;
    img.delete();
    push_hdr(8'h00, 16'h6007, 16'h6000);
    img.push_back(8'h52); img.push_back(8'h00);
    for (int k = 1; k <= 8; k++) img.push_back(8'(k));
    load_img();
    base = wr_count;
    @(negedge clk_48) start = 1'b1;
    @(negedge clk_48) start = 1'b0;
    for (i = 0; i < 500 && (wr_count - base) < 2; i++) @(negedge clk_48);
    checks++;
    if (wr_count - base < 2) begin
      errors++; $display("FAIL mid_progress got %0d want 2", wr_count - base);
    end
    reset = 1'b1;
    @(negedge clk_48);
    checks++;
    if ({busy, complete, error, ram_wr, cache_rd} !== 5'b00000 ||
        {cache_addr, ram_addr, ram_dout, loadpoint} !== 65'd0) begin
      errors++;
      $display("FAIL mid_reset got %b/%h want 0/0", {busy, complete, error, ram_wr, cache_rd},
               {cache_addr, ram_addr, ram_dout, loadpoint});
    end
    base = wr_count;
    repeat (4) @(negedge clk_48);
    reset = 1'b0;
    repeat (6) @(negedge clk_48);
    checks++;
    if (wr_count !== base || busy !== 1'b0) begin
      errors++; $display("FAIL mid_quiet got %0d/%b want %0d/0", wr_count, busy, base);
    end
    base = wr_count;
    run_load("reload");
    checks++;
    if ({complete, error, busy} !== 3'b100 || loadpoint !== 16'h6000 || wr_count - base !== 8) begin
      errors++;
      $display("FAIL reload_status got %b/%h/%0d want 100/6000/8", {complete, error, busy}, loadpoint,
               wr_count - base);
    end
    checks++;
    if ({ram[16'h6000], ram[16'h6001], ram[16'h6002], ram[16'h6003],
         ram[16'h6004], ram[16'h6005], ram[16'h6006], ram[16'h6007]} !== 64'h0102030405060708) begin
      errors++;
      $display("FAIL reload_ram got %h want 0102030405060708",
               {ram[16'h6000], ram[16'h6001], ram[16'h6002], ram[16'h6003],
                ram[16'h6004], ram[16'h6005], ram[16'h6006], ram[16'h6007]});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tape_end = 25'd0;
    test_reset();
    test_basic();
    test_early_marker();
    test_bad_range();
    test_truncated();
    test_name_limit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
